// File: rtl/i2c_pkg.sv
// Shared types and constants for the host-facing I2C target.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WRITE,
        WRITE_ACK,
        READ,
        READ_ACK,
        IGNORE
    } i2c_state_t;

    localparam logic I2C_RW_READ = 1'b1;

endpackage

// File: rtl/i2c_input_sync.sv
// Synchronises raw SCL/SDA into the clk domain and flags edges and bus conditions.
module i2c_input_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i2c_scl,
    input  logic i2c_sda_in,
    output logic scl,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_cond,
    output logic stop_cond
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_hist;
    logic                   sda_hist;

    // Flops reset to the idle (released) bus level so reset creates no false START.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_hist <= 1'b1;
            sda_hist <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], i2c_scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], i2c_sda_in};
            scl_hist <= scl_sync[SYNC_STAGES-1];
            sda_hist <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign scl        = scl_sync[SYNC_STAGES-1];
    assign sda        = sda_sync[SYNC_STAGES-1];
    assign scl_rise   = scl & ~scl_hist;
    assign scl_fall   = ~scl & scl_hist;
    assign start_cond = scl & scl_hist & sda_hist & ~sda;
    assign stop_cond  = scl & scl_hist & ~sda_hist & sda;

endmodule

// File: rtl/i2c_target.sv
// Byte-level I2C target: address match, write ACK, read shift-out, byte strobes.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0]  I2C_ADDRESS = 7'h2f,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i2c_scl,
    input  logic       i2c_sda_in,
    output logic       i2c_sda_oe,
    output logic       start,
    output logic       stop,
    output logic       addressed,
    output logic       rd_nwr,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_req,
    input  logic [7:0] tx_data
);

    logic unused_scl;
    logic sda, scl_rise, scl_fall, start_cond, stop_cond;

    i2c_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk        (clk),
        .rst        (rst),
        .i2c_scl    (i2c_scl),
        .i2c_sda_in (i2c_sda_in),
        .scl        (unused_scl),
        .sda        (sda),
        .scl_rise   (scl_rise),
        .scl_fall   (scl_fall),
        .start_cond (start_cond),
        .stop_cond  (stop_cond)
    );

    i2c_state_t state, state_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic [7:0] shift, shift_n, shifted;
    logic [7:0] tx_shift, tx_shift_n;
    logic       armed, armed_n;
    logic       load_pend;
    logic       oe_n, addressed_n, rd_nwr_n, start_n, stop_n, rx_valid_n, tx_req_n;
    logic [7:0] rx_data_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift      <= '0;
            tx_shift   <= '0;
            armed      <= 1'b0;
            load_pend  <= 1'b0;
            i2c_sda_oe <= 1'b0;
            addressed  <= 1'b0;
            rd_nwr     <= 1'b0;
            rx_data    <= '0;
            start      <= 1'b0;
            stop       <= 1'b0;
            rx_valid   <= 1'b0;
            tx_req     <= 1'b0;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            shift      <= shift_n;
            tx_shift   <= tx_shift_n;
            armed      <= armed_n;
            load_pend  <= tx_req;
            i2c_sda_oe <= oe_n;
            addressed  <= addressed_n;
            rd_nwr     <= rd_nwr_n;
            rx_data    <= rx_data_n;
            start      <= start_n;
            stop       <= stop_n;
            rx_valid   <= rx_valid_n;
            tx_req     <= tx_req_n;
        end
    end

    // 'armed' marks that the 8th bit has been taken and the next SCL fall opens the ACK slot.
    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        shift_n     = shift;
        tx_shift_n  = tx_shift;
        armed_n     = armed;
        oe_n        = i2c_sda_oe;
        addressed_n = addressed;
        rd_nwr_n    = rd_nwr;
        rx_data_n   = rx_data;
        start_n     = 1'b0;
        stop_n      = 1'b0;
        rx_valid_n  = 1'b0;
        tx_req_n    = 1'b0;
        shifted     = {shift[6:0], sda};

        if (load_pend) tx_shift_n = tx_data;

        if (start_cond) begin
            start_n     = 1'b1;
            state_n     = ADDR;
            bit_cnt_n   = '0;
            armed_n     = 1'b0;
            oe_n        = 1'b0;
            addressed_n = 1'b0;
        end else if (stop_cond) begin
            stop_n      = 1'b1;
            state_n     = IDLE;
            armed_n     = 1'b0;
            oe_n        = 1'b0;
            addressed_n = 1'b0;
        end else begin
            unique case (state)
                ADDR: begin
                    if (scl_rise && !armed) begin
                        shift_n   = shifted;
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (shifted[7:1] == I2C_ADDRESS) begin
                                rd_nwr_n = shifted[0];
                                armed_n  = 1'b1;
                            end else begin
                                state_n = IGNORE;
                            end
                        end
                    end else if (scl_fall && armed) begin
                        armed_n  = 1'b0;
                        oe_n     = 1'b1;
                        state_n  = ADDR_ACK;
                        tx_req_n = (rd_nwr == I2C_RW_READ);
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        addressed_n = 1'b1;
                        bit_cnt_n   = '0;
                        if (rd_nwr == I2C_RW_READ) begin
                            oe_n    = ~tx_shift[7];
                            state_n = READ;
                        end else begin
                            oe_n    = 1'b0;
                            state_n = WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (scl_rise && !armed) begin
                        shift_n   = shifted;
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            rx_data_n  = shifted;
                            rx_valid_n = 1'b1;
                            armed_n    = 1'b1;
                        end
                    end else if (scl_fall && armed) begin
                        armed_n = 1'b0;
                        oe_n    = 1'b1;
                        state_n = WRITE_ACK;
                    end
                end
                WRITE_ACK: begin
                    if (scl_fall) begin
                        oe_n    = 1'b0;
                        state_n = WRITE;
                    end
                end
                READ: begin
                    if (scl_fall) begin
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            oe_n    = 1'b0;
                            state_n = READ_ACK;
                        end else begin
                            oe_n       = ~tx_shift[6];
                            tx_shift_n = {tx_shift[6:0], 1'b0};
                        end
                    end
                end
                READ_ACK: begin
                    if (scl_rise && !armed) begin
                        if (!sda) begin
                            tx_req_n = 1'b1;
                            armed_n  = 1'b1;
                        end else begin
                            state_n = IGNORE;
                        end
                    end else if (scl_fall && armed) begin
                        armed_n = 1'b0;
                        oe_n    = ~tx_shift[7];
                        state_n = READ;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Bit-banged I2C controller driving i2c_target, checked against a transaction-level model.
module tb_i2c_target;
    import i2c_pkg::*;

    localparam int unsigned Q = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       sda_line;
    logic       i2c_sda_oe, start, stop, addressed, rd_nwr, rx_valid, tx_req;
    logic [7:0] rx_data;
    logic [7:0] tx_data = 8'h00;
    logic       tx_fixed = 1'b1;

    int checks = 0;
    int passes = 0;
    int n_start = 0, n_stop = 0, n_oe = 0;
    logic [7:0] rx_log[$];
    logic [7:0] tx_log[$];

    always #5 clk = ~clk;
    assign sda_line = m_sda & ~i2c_sda_oe;

    i2c_target #(.I2C_ADDRESS(7'h2f), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .i2c_scl    (scl),
        .i2c_sda_in (sda_line),
        .i2c_sda_oe (i2c_sda_oe),
        .start      (start),
        .stop       (stop),
        .addressed  (addressed),
        .rd_nwr     (rd_nwr),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_req     (tx_req),
        .tx_data    (tx_data)
    );

    // Host-side monitor: counts strobe cycles and plays the role of the read-data source.
    always @(negedge clk) begin
        if (start) n_start++;
        if (stop) n_stop++;
        if (i2c_sda_oe) n_oe++;
        if (rx_valid) rx_log.push_back(rx_data);
        if (tx_req) begin
            tx_data = tx_fixed ? 8'h9F : 8'($urandom);
            tx_log.push_back(tx_data);
        end
    end

    function automatic logic model_ack(input logic [7:0] addr);
        return (addr[7:1] == 7'h2f) ? 1'b0 : 1'b1;
    endfunction

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, output logic got);
        wait_q(); m_sda = b;
        wait_q(); scl = 1'b1;
        wait_q(); got = sda_line;
        wait_q(); scl = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic g;
        for (int i = 7; i >= 0; i--) send_bit(b[i], g);
        send_bit(1'b1, ack);
    endtask

    task automatic recv_byte(input logic ack, output logic [7:0] b);
        logic g;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, g);
            b[i] = g;
        end
        send_bit(ack, g);
    endtask

    task automatic do_start();
        wait_q(); m_sda = 1'b1;
        wait_q(); scl = 1'b1;
        wait_q(); m_sda = 1'b0;
        wait_q(); scl = 1'b0;
    endtask

    task automatic do_stop();
        wait_q(); m_sda = 1'b0;
        wait_q(); scl = 1'b1;
        wait_q(); m_sda = 1'b1;
        wait_q(); wait_q();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if ({i2c_sda_oe, start, stop, addressed, rd_nwr, rx_valid, tx_req, rx_data} !== 15'd0)
            $display("FAIL reset_outputs: got %b required 0",
                     {i2c_sda_oe, start, stop, addressed, rd_nwr, rx_valid, tx_req, rx_data});
        else passes++;
        checks++;
        if (dut.state !== IDLE) $display("FAIL reset_state: got %0d required IDLE", dut.state);
        else passes++;
        rst = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_write();
        logic [7:0] bs[$] = '{8'h01, 8'h02, 8'h00, 8'h05, 8'h02, 8'h9F, 8'h00};
        logic ack;
        int s0 = n_start, p0 = n_stop, r0 = rx_log.size();
        do_start();
        send_byte(8'h5E, ack);
        checks++;
        if (ack !== model_ack(8'h5E)) $display("FAIL write_addr_ack: got %b required %b", ack, model_ack(8'h5E));
        else passes++;
        repeat (6) @(negedge clk);
        checks++;
        if ({addressed, rd_nwr} !== 2'b10) $display("FAIL write_addressed_rdnwr: got %b required 10", {addressed, rd_nwr});
        else passes++;
        foreach (bs[i]) begin
            send_byte(bs[i], ack);
            checks++;
            if (ack !== 1'b0) $display("FAIL write_data_ack %0d: got %b required 0", i, ack);
            else passes++;
        end
        do_stop();
        checks++;
        if (rx_log.size() - r0 != bs.size()) $display("FAIL write_rx_count: got %0d required %0d", rx_log.size() - r0, bs.size());
        else passes++;
        foreach (bs[i]) begin
            if (r0 + i < rx_log.size()) begin
                checks++;
                if (rx_log[r0 + i] !== bs[i]) $display("FAIL write_rx_data %0d: got %h required %h", i, rx_log[r0 + i], bs[i]);
                else passes++;
            end
        end
        checks++;
        if (n_start - s0 != 1 || n_stop - p0 != 1)
            $display("FAIL write_start_stop: got %0d/%0d required 1/1", n_start - s0, n_stop - p0);
        else passes++;
        checks++;
        if (addressed !== 1'b0) $display("FAIL write_addressed_after_stop: got %b required 0", addressed);
        else passes++;
    endtask

    task automatic test_read();
        logic ack;
        logic [7:0] b;
        int t0, o0, r0;
        tx_fixed = 1'b1;
        t0 = tx_log.size();
        r0 = rx_log.size();
        do_start();
        send_byte(8'h5F, ack);
        checks++;
        if (ack !== 1'b0) $display("FAIL read_addr_ack: got %b required 0", ack);
        else passes++;
        repeat (6) @(negedge clk);
        checks++;
        if ({addressed, rd_nwr} !== 2'b11) $display("FAIL read_addressed_rdnwr: got %b required 11", {addressed, rd_nwr});
        else passes++;
        for (int i = 0; i < 5; i++) begin
            recv_byte((i == 4) ? 1'b1 : 1'b0, b);
            checks++;
            if (b !== 8'h9F) $display("FAIL read_byte %0d: got %h required 9f", i, b);
            else passes++;
        end
        o0 = n_oe;
        do_stop();
        checks++;
        if (n_oe != o0) $display("FAIL read_oe_after_nack: got %0d cycles required 0", n_oe - o0);
        else passes++;
        checks++;
        if (tx_log.size() - t0 != 5) $display("FAIL read_tx_req_count: got %0d required 5", tx_log.size() - t0);
        else passes++;
        checks++;
        if (rx_log.size() != r0) $display("FAIL read_no_rx_valid: got %0d required 0", rx_log.size() - r0);
        else passes++;
    endtask

    task automatic test_bad_addr();
        logic ack;
        int o0 = n_oe, r0 = rx_log.size(), t0 = tx_log.size();
        do_start();
        send_byte(8'hA0, ack);
        checks++;
        if (ack !== model_ack(8'hA0)) $display("FAIL bad_addr_ack: got %b required %b", ack, model_ack(8'hA0));
        else passes++;
        for (int i = 0; i < 2; i++) begin
            send_byte(8'($urandom), ack);
            checks++;
            if (ack !== 1'b1) $display("FAIL bad_addr_data_ack %0d: got %b required 1", i, ack);
            else passes++;
        end
        do_stop();
        checks++;
        if (n_oe != o0 || rx_log.size() != r0 || tx_log.size() != t0)
            $display("FAIL bad_addr_quiet: got oe=%0d rx=%0d tx=%0d required 0/0/0",
                     n_oe - o0, rx_log.size() - r0, tx_log.size() - t0);
        else passes++;
    endtask

    task automatic test_repeated_start();
        logic ack, g;
        logic [7:0] b;
        int s0 = n_start, r0 = rx_log.size(), t0;
        int nread = int'($urandom_range(2, 4));
        tx_fixed = 1'b0;
        do_start();
        send_byte(8'h5E, ack);
        send_byte(8'h01, ack);
        for (int i = 0; i < 4; i++) send_bit(1'($urandom), g);
        t0 = tx_log.size();
        do_start();
        send_byte(8'h5F, ack);
        checks++;
        if (ack !== 1'b0) $display("FAIL rs_read_addr_ack: got %b required 0", ack);
        else passes++;
        repeat (6) @(negedge clk);
        checks++;
        if (rd_nwr !== 1'b1) $display("FAIL rs_rd_nwr: got %b required 1", rd_nwr);
        else passes++;
        for (int i = 0; i < nread; i++) begin
            recv_byte((i == nread - 1) ? 1'b1 : 1'b0, b);
            if (t0 + i < tx_log.size()) begin
                checks++;
                if (b !== tx_log[t0 + i]) $display("FAIL rs_read_byte %0d: got %h required %h", i, b, tx_log[t0 + i]);
                else passes++;
            end
        end
        do_stop();
        checks++;
        if (tx_log.size() - t0 != nread) $display("FAIL rs_tx_req_count: got %0d required %0d", tx_log.size() - t0, nread);
        else passes++;
        checks++;
        if (n_start - s0 != 2) $display("FAIL rs_start_count: got %0d required 2", n_start - s0);
        else passes++;
        checks++;
        if (rx_log.size() - r0 != 1 || rx_log[rx_log.size() - 1] !== 8'h01)
            $display("FAIL rs_rx: got count %0d last %h required 1 / 01", rx_log.size() - r0, rx_log[rx_log.size() - 1]);
        else passes++;
    endtask

    task automatic run_write(input logic [7:0] addr, input int n, input string name);
        logic ack;
        logic [7:0] bs[$];
        int r0 = rx_log.size();
        logic exp_ack = model_ack(addr);
        do_start();
        send_byte(addr, ack);
        checks++;
        if (ack !== exp_ack) $display("FAIL %s_addr_ack: got %b required %b", name, ack, exp_ack);
        else passes++;
        for (int i = 0; i < n; i++) begin
            bs.push_back(8'($urandom));
            send_byte(bs[i], ack);
        end
        do_stop();
        if (exp_ack) bs.delete();
        checks++;
        if (rx_log.size() - r0 != bs.size()) $display("FAIL %s_rx_count: got %0d required %0d", name, rx_log.size() - r0, bs.size());
        else passes++;
        foreach (bs[i]) begin
            if (r0 + i < rx_log.size()) begin
                checks++;
                if (rx_log[r0 + i] !== bs[i]) $display("FAIL %s_rx_data %0d: got %h required %h", name, i, rx_log[r0 + i], bs[i]);
                else passes++;
            end
        end
    endtask

    task automatic test_reset_mid_ack();
        logic ack, g;
        do_start();
        send_byte(8'h5E, ack);
        for (int i = 0; i < 8; i++) send_bit(1'($urandom), g);
        wait_q();
        checks++;
        if (i2c_sda_oe !== 1'b1) $display("FAIL rst_ack_driven: got %b required 1", i2c_sda_oe);
        else passes++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (i2c_sda_oe !== 1'b0 || dut.state !== IDLE)
            $display("FAIL rst_release: got oe=%b state=%0d required oe=0 IDLE", i2c_sda_oe, dut.state);
        else passes++;
        repeat (10) @(negedge clk);
        do_stop();
        run_write(8'h5E, 3, "rst_recover");
    endtask

    task automatic test_stop_mid_byte();
        logic ack, g;
        int p0, r0;
        do_start();
        send_byte(8'h5E, ack);
        p0 = n_stop;
        r0 = rx_log.size();
        for (int i = 0; i < 3; i++) send_bit(1'($urandom), g);
        do_stop();
        checks++;
        if (n_stop - p0 != 1 || rx_log.size() != r0 || dut.state !== IDLE)
            $display("FAIL stop_mid_byte: got stop=%0d rx=%0d state=%0d required 1/0/IDLE",
                     n_stop - p0, rx_log.size() - r0, dut.state);
        else passes++;
    endtask

    task automatic test_random_writes();
        for (int t = 0; t < 3; t++) begin
            logic [7:0] addr = ($urandom_range(0, 2) != 0) ? 8'h5E : {7'($urandom), 1'b0};
            run_write(addr, int'($urandom_range(1, 4)), "rand_write");
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_bad_addr();
        test_repeated_start();
        test_reset_mid_ack();
        test_stop_mid_byte();
        test_random_writes();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
